debounced_edge_pulser: RTL and testbench

//   Multi-channel input conditioner for buttons/switches. Per channel: 2-flop synchronizer, debounce

---
 rtl/edge_pulse_pkg.sv | 19 +
 rtl/debounce_channel.sv | 87 ++++++++
 rtl/debounced_edge_pulser.sv | 39 +++
 tb/tb_debounced_edge_pulser.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pulse_pkg.sv
// Shared definitions for the debounced edge pulser: edge-select modes and
// the debounce counter sizing helper.
package edge_pulse_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  // Width needed to count 0..cycles-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    int unsigned w;
    w = int'($clog2(cycles));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-flop synchronizer, debounce counter, accepted level,
// direction-qualified event pulse and sticky event flag.
module debounce_channel
  import edge_pulse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic        RESET_LEVEL     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inp,
  input  logic [1:0] mode,
  input  logic       clear,
  output logic       level_out,
  output logic       pulse_out,
  output logic       event_flag
);

  localparam int unsigned    CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             edge_evt;
  logic             fire;
  logic             pulse;
  logic             flag;
  edge_mode_e       edge_mode;

  assign edge_mode = edge_mode_e'(mode);

  // Any sample matching the accepted level restarts the qualification run.
  always_comb begin
    count_nxt = '0;
    level_nxt = level;
    edge_evt  = 1'b0;
    if (sync2 != level) begin
      if (count == CNT_MAX) begin
        level_nxt = sync2;
        edge_evt  = 1'b1;
      end else begin
        count_nxt = count + CNT_W'(1);
      end
    end
  end

  // On an accepted change, sync2 is the new level and gives the direction.
  always_comb begin
    fire = 1'b0;
    if (edge_evt) begin
      case (edge_mode)
        EDGE_RISE: fire = sync2;
        EDGE_FALL: fire = ~sync2;
        EDGE_BOTH: fire = 1'b1;
        default:   fire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= RESET_LEVEL;
      sync2 <= RESET_LEVEL;
      level <= RESET_LEVEL;
      count <= '0;
      pulse <= 1'b0;
      flag  <= 1'b0;
    end else begin
      sync1 <= inp;
      sync2 <= sync1;
      level <= level_nxt;
      count <= count_nxt;
      pulse <= fire;
      // A new event wins over a same-cycle clear so it is never lost.
      flag  <= fire | (flag & ~clear);
    end
  end

  assign level_out  = level;
  assign pulse_out  = pulse;
  assign event_flag = flag;

endmodule

// File: rtl/debounced_edge_pulser.sv
// Multi-channel button/switch conditioner: independent debounce channels plus
// a combined "any event pending" indication.
module debounced_edge_pulser
  import edge_pulse_pkg::*;
#(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic        RESET_LEVEL     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   inp,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clear,
  output logic [CHANNELS-1:0]   level_out,
  output logic [CHANNELS-1:0]   pulse_out,
  output logic [CHANNELS-1:0]   event_flags,
  output logic                  any_event
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .inp       (inp[g]),
      .mode      (mode[2*g +: 2]),
      .clear     (clear[g]),
      .level_out (level_out[g]),
      .pulse_out (pulse_out[g]),
      .event_flag(event_flags[g])
    );
  end

  assign any_event = |event_flags;

endmodule

// File: tb/tb_debounced_edge_pulser.sv
// Bench for debounced_edge_pulser: directed scenarios plus random traffic,
// every cycle compared against a sample-history reference model.
module tb_debounced_edge_pulser;

  localparam int   CH   = 4;
  localparam int   DC   = 4;
  localparam logic RL   = 1'b1;
  localparam int   NM   = CH + 1;   // model slot CH is the DEBOUNCE_CYCLES=1 build
  localparam int   HMAX = 4096;
  localparam int   DCYC [NM] = '{DC, DC, DC, DC, 1};

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] inp;
  logic [2*CH-1:0] mode;
  logic [CH-1:0] clear;
  logic [CH-1:0] level_out, pulse_out, event_flags;
  logic          any_event;
  logic [0:0]    level1, pulse1, flags1;
  logic          any1;

  int checks = 0;
  int errors = 0;

  debounced_edge_pulser #(
    .CHANNELS(CH), .DEBOUNCE_CYCLES(DC), .RESET_LEVEL(RL)
  ) dut (
    .clk(clk), .rst(rst), .inp(inp), .mode(mode), .clear(clear),
    .level_out(level_out), .pulse_out(pulse_out),
    .event_flags(event_flags), .any_event(any_event)
  );

  debounced_edge_pulser #(
    .CHANNELS(1), .DEBOUNCE_CYCLES(1), .RESET_LEVEL(RL)
  ) dut1 (
    .clk(clk), .rst(rst), .inp(inp[0]), .mode(mode[1:0]), .clear(clear[0]),
    .level_out(level1), .pulse_out(pulse1),
    .event_flags(flags1), .any_event(any1)
  );

  always #5 clk = ~clk;

  // Reference model: level flips when the synchronized input has differed
  // from it on each of the last D edges; sync value seen on edge e is the
  // raw sample taken on edge e-2 (idle level before that).
  bit hist [NM][HMAX];
  bit m_lvl [NM];
  bit m_pulse [NM];
  bit m_flag [NM];
  int t = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit sync_seen(input int c, input int e);
    return (e >= 3) ? hist[c][e-3] : RL;
  endfunction

  task automatic model_edge();
    if (rst) begin
      t = 0;
      for (int c = 0; c < NM; c++) begin
        m_lvl[c] = RL; m_pulse[c] = 1'b0; m_flag[c] = 1'b0;
      end
    end else begin
      t++;
      if (t > HMAX) begin
        $display("FAIL history: got %0d expected <= %0d", t, HMAX);
        $fatal(1);
      end
      for (int c = 0; c < NM; c++) begin
        int cm;
        bit fire, nl;
        bit [1:0] md;
        cm = (c == CH) ? 0 : c;
        hist[c][t-1] = inp[cm];
        fire = 1'b1;
        for (int k = 0; k < DCYC[c]; k++)
          if (sync_seen(c, t - k) == m_lvl[c]) fire = 1'b0;
        nl = fire ? ~m_lvl[c] : m_lvl[c];
        md = mode[2*cm +: 2];
        m_pulse[c] = fire && (nl ? md[0] : md[1]);
        m_flag[c]  = m_pulse[c] | (m_flag[c] & ~clear[cm]);
        m_lvl[c]   = nl;
      end
    end
  endtask

  task automatic compare_all();
    logic [CH-1:0] el, ep, ef;
    for (int c = 0; c < CH; c++) begin
      el[c] = m_lvl[c]; ep[c] = m_pulse[c]; ef[c] = m_flag[c];
    end
    check("level_out",   32'(level_out),   32'(el));
    check("pulse_out",   32'(pulse_out),   32'(ep));
    check("event_flags", 32'(event_flags), 32'(ef));
    check("any_event",   32'(any_event),   32'(|ef));
    check("d1_level",    32'(level1),      32'(m_lvl[CH]));
    check("d1_pulse",    32'(pulse1),      32'(m_pulse[CH]));
    check("d1_flag",     32'(flags1),      32'(m_flag[CH]));
    check("d1_any",      32'(any1),        32'(m_flag[CH]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic clear_all();
    clear = '1;
    tick();
    clear = '0;
  endtask

  task automatic rand_run(input int n);
    int hold [CH];
    for (int c = 0; c < CH; c++) hold[c] = 0;
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          hold[c] = $urandom_range(1, 9);
          if ($urandom_range(0, 1) == 1) inp[c] = ~inp[c];
        end else begin
          hold[c]--;
        end
        clear[c] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 19) == 0) mode = 8'($urandom);
      tick();
    end
    clear = '0;
  endtask

  initial begin
    int p2, p3;
    rst = 1'b1; inp = '1; mode = 8'hAA; clear = '0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (8) tick();

    // ch0 RISE: the release (fall) is silent, the press-release rise pulses on edge 6
    mode = 8'h01;
    clear_all();
    inp[0] = 1'b0;
    repeat (10) tick();
    check("t2_level_low", 32'(level_out[0]), 32'd0);
    check("t2_no_fall_flag", 32'(event_flags[0]), 32'd0);
    inp[0] = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("t2_pulse_edge", 32'(pulse_out[0]), (e == 6) ? 32'd1 : 32'd0);
      check("t6_d1_rise_edge", 32'(pulse1), (e == 3) ? 32'd1 : 32'd0);
    end
    check("t2_flag", 32'(event_flags[0]), 32'd1);
    check("t2_any", 32'(any_event), 32'd1);
    tick();
    check("t2_pulse_one_cycle", 32'(pulse_out[0]), 32'd0);

    // clear colliding with the event keeps the flag; a later clear drops it
    inp[0] = 1'b0;
    repeat (10) tick();
    clear_all();
    inp[0] = 1'b1;
    repeat (5) tick();
    clear[0] = 1'b1;
    tick();
    check("t5_pulse", 32'(pulse_out[0]), 32'd1);
    check("t5_flag_kept", 32'(event_flags[0]), 32'd1);
    tick();
    check("t5_flag_cleared", 32'(event_flags[0]), 32'd0);
    clear = '0;

    // ch1 BOTH: 3-cycle glitch rejected, 4-cycle low accepted
    mode = 8'h0C;
    clear_all();
    inp[1] = 1'b0;
    repeat (3) tick();
    inp[1] = 1'b1;
    repeat (10) tick();
    check("t3_glitch_level", 32'(level_out[1]), 32'd1);
    check("t3_glitch_flag", 32'(event_flags[1]), 32'd0);
    inp[1] = 1'b0;
    repeat (4) tick();
    inp[1] = 1'b1;
    tick();
    tick();
    check("t3_accept_level", 32'(level_out[1]), 32'd0);
    check("t3_accept_pulse", 32'(pulse_out[1]), 32'd1);
    repeat (10) tick();
    check("t3_return_level", 32'(level_out[1]), 32'd1);

    // ch2 BOTH vs ch3 OFF on the same toggle
    mode = 8'h30;
    clear_all();
    p2 = 0; p3 = 0;
    inp[3:2] = 2'b00;
    repeat (10) begin tick(); p2 += int'(pulse_out[2]); p3 += int'(pulse_out[3]); end
    check("t4_off_level_low", 32'(level_out[3]), 32'd0);
    inp[3:2] = 2'b11;
    repeat (10) begin tick(); p2 += int'(pulse_out[2]); p3 += int'(pulse_out[3]); end
    check("t4_both_pulses", 32'(p2), 32'd2);
    check("t4_off_pulses", 32'(p3), 32'd0);
    check("t4_off_flag", 32'(event_flags[3]), 32'd0);
    check("t4_off_level_high", 32'(level_out[3]), 32'd1);

    rand_run(400);

    // reset in the middle of a debounce with all inputs held low
    mode = 8'hAA; clear = '0; inp = '1;
    repeat (10) tick();
    inp = '0;
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    check("t1_rst_level", 32'(level_out), 32'hF);
    check("t1_rst_pulse", 32'(pulse_out), 32'd0);
    check("t1_rst_flags", 32'(event_flags), 32'd0);
    check("t1_rst_any", 32'(any_event), 32'd0);
    check("t1_rst_d1_level", 32'(level1), 32'd1);
    repeat (2) tick();
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("t1_release_pulse", 32'(pulse_out), (e == 6) ? 32'hF : 32'h0);
      check("t6_d1_fall_edge", 32'(pulse1), (e == 3) ? 32'd1 : 32'd0);
    end
    tick();
    check("t1_pulse_once", 32'(pulse_out), 32'h0);

    rand_run(300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
